// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl
//
// This block takes 8-bit words from two requesters and arbitrates between
// them round-robin. It scans each accepted word MSB first through a 4-bit
// history window. It counts how many times the window equals a programmable
// 4-bit pattern, with overlapping matches counted. It then presents the count
// to a consumer using a valid/ready handshake.
//
// State table
//   state | meaning
//   IDLE  | waiting for a word; grants one requester; pattern writable
//   SHIFT | consuming one bit of the latched word per clock (8 clocks)
//   DONE  | result presented; held until res_ready
//
// Ports
//   clk, resetn            clock, synchronous active-low reset
//   req0_valid/data/ready  requester 0 word handshake
//   req1_valid/data/ready  requester 1 word handshake
//   cfg_we, cfg_pattern    pattern register write (IDLE only)
//   busy                   high whenever not in IDLE
//   res_valid/id/count     scan result; res_ready accepts it

module pattern_scan_ctrl (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    input  logic       cfg_we,
    input  logic [3:0] cfg_pattern,
    output logic       busy,
    output logic       res_valid,
    output logic       res_id,
    output logic [3:0] res_count,
    input  logic       res_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] data_q;
    logic [3:0] pattern;
    logic [3:0] window;
    logic [2:0] bit_cnt;
    logic [3:0] count;
    logic       last_grant;
    logic       res_id_q;

    logic       grant;
    logic       accept;
    logic [3:0] window_next;
    logic       in_idle;

    // On a tie, the requester that was not served last wins. Otherwise, the
    // only valid requester wins.
    assign grant       = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign in_idle     = resetn && (state == IDLE);
    assign req0_ready  = in_idle && req0_valid && !grant;
    assign req1_ready  = in_idle && req1_valid && grant;
    assign accept      = req0_ready || req1_ready;

    // data_q shifts left, so bit 7 of the remaining word is always next
    assign window_next = {window[2:0], data_q[7]};

    // These are gated by resetn so they read 0 during reset even before the
    // first reset edge.
    assign busy        = resetn && (state != IDLE);
    assign res_valid   = resetn && (state == DONE);
    assign res_id      = res_id_q;
    assign res_count   = count;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            pattern    <= 4'b1010;
            last_grant <= 1'b1;
            window     <= 4'd0;
            bit_cnt    <= 3'd0;
            count      <= 4'd0;
            res_id_q   <= 1'b0;
            data_q     <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_we) begin
                        pattern <= cfg_pattern;
                    end
                    if (accept) begin
                        data_q     <= grant ? req1_data : req0_data;
                        res_id_q   <= grant;
                        last_grant <= grant;
                        window     <= 4'd0;
                        bit_cnt    <= 3'd0;
                        count      <= 4'd0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    window  <= window_next;
                    data_q  <= {data_q[6:0], 1'b0};
                    bit_cnt <= bit_cnt + 3'd1;
                    // A match needs a full window of this word's bits, so the
                    // first check happens on the fourth bit (bit_cnt == 3).
                    if ((bit_cnt >= 3'd3) && (window_next == pattern)) begin
                        count <= count + 4'd1;
                    end
                    if (bit_cnt == 3'd7) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Testbench for pattern_scan_ctrl.
// The bench keeps its own model of the expected result. Each accept is
// modelled as its own transaction: the model records the owner, counts the
// pattern occurrences in the word directly, and tracks the age since accept.
// The outputs are compared against that model on every falling edge.
// Directed scenarios add literal expectations on top of the model.

module tb_pattern_scan_ctrl;

    logic       clk;
    logic       resetn;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       cfg_we;
    logic [3:0] cfg_pattern;
    logic       busy;
    logic       res_valid;
    logic       res_id;
    logic [3:0] res_count;
    logic       res_ready;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_en = 0;

    // model state
    bit         m_active = 0;
    int         m_age = 0;
    bit         m_id = 0;
    int         m_cnt = 0;
    bit         m_last = 1;
    logic [3:0] m_pat = 4'b1010;
    bit         mg;
    bit         eg;

    int grant_who[$];
    int grant_cyc[$];

    pattern_scan_ctrl dut (
        .clk         (clk),
        .resetn      (resetn),
        .req0_valid  (req0_valid),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_id      (res_id),
        .res_count   (res_count),
        .res_ready   (res_ready)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Number of 4-bit windows (oldest bit in the MSB) inside the word that
    // equal the pattern.
    function automatic int count_matches(input logic [7:0] d, input logic [3:0] p);
        int n;
        logic [3:0] w;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            w = d[7-i -: 4];
            if (w == p) n++;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!resetn) begin
            m_active = 0;
            m_age    = 0;
            m_pat    = 4'b1010;
            m_last   = 1;
        end else if (!m_active) begin
            mg = (req0_valid && req1_valid) ? ~m_last : req1_valid;
            if (cfg_we) m_pat = cfg_pattern;
            if (req0_valid || req1_valid) begin
                m_active = 1;
                m_age    = 0;
                m_id     = mg;
                m_last   = mg;
                m_cnt    = count_matches(mg ? req1_data : req0_data, m_pat);
            end
        end else if (m_age < 8) begin
            m_age++;
        end else if (res_ready) begin
            m_active = 0;
        end
    end

    always @(negedge clk) begin
        if (req0_valid && req0_ready) begin grant_who.push_back(0); grant_cyc.push_back(cyc); end
        if (req1_valid && req1_ready) begin grant_who.push_back(1); grant_cyc.push_back(cyc); end
        if (chk_en) begin
            if (!resetn) begin
                chk("rst_req0_ready", req0_ready, 0);
                chk("rst_req1_ready", req1_ready, 0);
                chk("rst_busy", busy, 0);
                chk("rst_res_valid", res_valid, 0);
            end else if (!m_active) begin
                eg = (req0_valid && req1_valid) ? ~m_last : req1_valid;
                chk("m_req0_ready", req0_ready, int'(req0_valid && !eg));
                chk("m_req1_ready", req1_ready, int'(req1_valid && eg));
                chk("m_busy", busy, 0);
                chk("m_res_valid", res_valid, 0);
            end else begin
                chk("m_req0_ready", req0_ready, 0);
                chk("m_req1_ready", req1_ready, 0);
                chk("m_busy", busy, 1);
                chk("m_res_valid", res_valid, int'(m_age >= 8));
                if (m_age >= 8) begin
                    chk("m_res_id", res_id, int'(m_id));
                    chk("m_res_count", res_count, m_cnt);
                end
            end
        end
    end

    task automatic do_reset();
        resetn = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_res_valid", res_valid, 0);
        chk("reset_res_id", res_id, 0);
        chk("reset_res_count", res_count, 0);
        resetn = 1;
    endtask

    task automatic send(input bit who, input logic [7:0] d, input int exp_cnt, input int hold);
        bit got;
        int n;
        logic       id0;
        logic [3:0] cnt0;
        if (who) begin req1_valid = 1; req1_data = d; end
        else begin req0_valid = 1; req0_data = d; end
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (who ? req1_ready : req0_ready) got = 1;
        end
        chk("accept_seen", int'(got), 1);
        @(posedge clk);
        #1;
        req0_valid = 0;
        req1_valid = 0;
        cfg_we     = 0;
        if (!got) return;
        got = 0;
        n = 0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(posedge clk);
            #1;
            if (res_valid) begin got = 1; n = i; end
        end
        chk("res_latency", n, 8);
        chk("res_id", res_id, int'(who));
        chk("res_count", res_count, exp_cnt);
        chk("model_count", m_cnt, exp_cnt);
        id0  = res_id;
        cnt0 = res_count;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", res_valid, 1);
            chk("hold_id", res_id, int'(id0));
            chk("hold_count", res_count, int'(cnt0));
            chk("hold_busy", busy, 1);
            chk("hold_ready0", req0_ready, 0);
            chk("hold_ready1", req1_ready, 0);
        end
        res_ready = 1;
        @(posedge clk);
        #1;
        res_ready = 0;
        chk("idle_after_handshake", busy, 0);
        chk("valid_after_handshake", res_valid, 0);
    endtask

    initial begin
        resetn = 0; req0_valid = 0; req0_data = 0; req1_valid = 0; req1_data = 0;
        cfg_we = 0; cfg_pattern = 0; res_ready = 0;
        @(posedge clk);
        #1;
        chk_en = 1;
        do_reset();
        @(posedge clk);
        #1;

        // default pattern, with 5 cycles of result backpressure
        send(0, 8'hAA, 3, 5);

        // tie arbitration from reset, consumer always ready
        do_reset();
        @(posedge clk);
        #1;
        grant_who.delete();
        grant_cyc.delete();
        res_ready  = 1;
        req0_data  = 8'hAA;
        req1_data  = 8'h55;
        req0_valid = 1;
        req1_valid = 1;
        repeat (45) @(posedge clk);
        #1;
        req0_valid = 0;
        req1_valid = 0;
        repeat (15) @(posedge clk);
        #1;
        res_ready = 0;
        chk("tie_grant_count", int'(grant_who.size() >= 4), 1);
        if (grant_who.size() >= 4) begin
            chk("tie_grant0", grant_who[0], 0);
            chk("tie_grant1", grant_who[1], 1);
            chk("tie_grant2", grant_who[2], 0);
            chk("tie_grant3", grant_who[3], 1);
            chk("tie_spacing", grant_cyc[1] - grant_cyc[0], 10);
        end

        // a pattern write during SHIFT must be dropped
        fork
            send(0, 8'hAA, 3, 0);
            begin
                repeat (3) @(posedge clk);
                #1;
                cfg_we = 1;
                cfg_pattern = 4'b0000;
                @(posedge clk);
                #1;
                cfg_we = 0;
            end
        join
        send(0, 8'h00, 0, 0);

        // maximum count
        cfg_we = 1;
        cfg_pattern = 4'b1111;
        @(posedge clk);
        #1;
        cfg_we = 0;
        send(1, 8'hFF, 5, 0);

        // a pattern written on the accept edge applies to that word
        cfg_we = 1;
        cfg_pattern = 4'b0101;
        send(0, 8'h55, 3, 2);

        // reset three edges into SHIFT
        req1_valid = 1;
        req1_data  = 8'hFF;
        begin
            bit got;
            got = 0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (req1_ready) got = 1;
            end
            chk("midscan_accept", int'(got), 1);
        end
        @(posedge clk);
        #1;
        req1_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 0;
        @(posedge clk);
        #1;
        resetn = 1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            chk("abandoned_no_valid", res_valid, 0);
        end
        req0_valid = 1;
        req1_valid = 1;
        @(negedge clk);
        chk("post_reset_tie_r0", req0_ready, 1);
        chk("post_reset_tie_r1", req1_ready, 0);
        req0_valid = 0;
        req1_valid = 0;
        @(posedge clk);
        #1;
        send(0, 8'hAA, 3, 0);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 Port `clk`, input, 1 bit: clock; all state changes on its rising edge.
REQ-002 Port `resetn`, input, 1 bit: reset, synchronous, active-low.
REQ-003 Port `req0_valid`, input, 1 bit: requester 0 offers a word.
REQ-004 Port `req0_data`, input, 8 bits: requester 0 word, scanned MSB first.
REQ-005 Port `req0_ready`, output, 1 bit: controller accepts the requester 0 word this cycle.
REQ-006 Port `req1_valid`, input, 1 bit: requester 1 offers a word.
REQ-007 Port `req1_data`, input, 8 bits: requester 1 word, scanned MSB first.
REQ-008 Port `req1_ready`, output, 1 bit: controller accepts the requester 1 word this cycle.
REQ-009 Port `cfg_we`, input, 1 bit: pattern register write strobe.
REQ-010 Port `cfg_pattern`, input, 4 bits: new pattern; bit 3 is the oldest bit of the window.
REQ-011 Port `busy`, output, 1 bit: controller is not in IDLE.
REQ-012 Port `res_valid`, output, 1 bit: a scan result is available.
REQ-013 Port `res_id`, output, 1 bit: requester that owns the result.
REQ-014 Port `res_count`, output, 4 bits: number of pattern matches in the word.
REQ-015 Port `res_ready`, input, 1 bit: result consumer accepts the result.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-017 In IDLE, `reqN_ready` SHALL be high only for the granted requester, and only while its valid is high; both readys SHALL be low in SHIFT and DONE.
REQ-018 Arbitration SHALL be round-robin:
- only one requester valid: that requester is granted;
- both valid: the requester not granted most recently wins;
- the last-grant pointer SHALL reset to 1, so requester 0 wins the first tie.
REQ-019 On an accept edge (valid && ready), the controller SHALL:
- latch the data word and the requester id;
- clear the 4-bit history window, the bit counter and the match count;
- move to SHIFT.
REQ-020 In SHIFT, each edge SHALL consume one bit, from bit 7 down to bit 0: window_next = {window[2:0], bit}.
REQ-021 A match SHALL be counted on an edge when both hold: at least 4 bits of the current word have been consumed, including this bit; and window_next == the pattern register.
- Overlapping matches count; history never crosses word boundaries; maximum count is 5.
REQ-022 After the 8th bit edge, the FSM SHALL enter DONE. `res_valid` SHALL be high from exactly 8 edges after the accept edge.
REQ-023 In DONE, `res_valid`, `res_id` and `res_count` SHALL hold stable until `res_ready` is high. The FSM SHALL then return to IDLE on that edge.
- No new word is accepted in the same cycle as the result handshake.
- Minimum spacing between accepts: 10 cycles.
REQ-024 `res_valid` SHALL be low in IDLE and SHIFT. `busy` SHALL be high in SHIFT and DONE.
REQ-025 The pattern register SHALL be written from `cfg_pattern` on an edge with `cfg_we` high, but only while in IDLE. Writes in SHIFT or DONE SHALL be dropped silently.
REQ-026 If `cfg_we` is high and an accept happens on the same IDLE edge, the new pattern SHALL apply to that word.

Reset
REQ-027 While `resetn` is low, at the edge the block SHALL set:
- state = IDLE, pattern = 4'b1010, last-grant pointer = 1;
- window, bit counter and count = 0;
- `res_id` = 0.
REQ-028 While `resetn` is low, `req0_ready`, `req1_ready`, `busy` and `res_valid` SHALL all be 0.
REQ-029 Reset asserted in SHIFT or DONE SHALL abandon the word. No result SHALL be produced for it.

Verification
REQ-030 Scan with default pattern: reset, then req0 offers 8'hAA. Required:
- req0 accepted;
- `res_valid` rises 8 edges after the accept;
- res_id = 0, res_count = 3.
REQ-031 Arbitration tie: both requesters valid continuously, `res_ready` = 1. Required: grants alternate 0,1,0,1; each result's `res_id` matches its grant.
REQ-032 Maximum count: cfg_we with pattern 4'b1111 in IDLE, then req1 offers 8'hFF. Required: res_count = 5, res_id = 1.
REQ-033 Result backpressure: `res_ready` held low 5 cycles in DONE. Required:
- result outputs stable;
- `busy` = 1;
- both readys = 0;
- IDLE is entered on the edge `res_ready` rises.
REQ-034 Dropped config write: cfg_we with 4'b0000 during SHIFT. Required: the write is ignored; a following 8'h00 word gives res_count = 0 under pattern 1010.
REQ-035 Reset mid-scan: `resetn` low for 1 cycle, 3 edges into SHIFT. Required: no `res_valid`; pattern reads back as 1010; the next tie grants req0.
